// File: rtl/tank_pkg.sv
// Shared types and screen constants for the tank game shell logic.
package tank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    IMPACT = 2'd2
  } shell_state_t;

  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;

  // Renderer cannot show a shell above the top edge, so clamp it to row 0.
  function automatic logic [9:0] screen_y(input logic signed [10:0] y);
    return y[10] ? 10'd0 : y[9:0];
  endfunction

endpackage

// File: rtl/box_collide.sv
// Square hit-box test: shell is inside when both axis distances are within the radius.
module box_collide #(
  parameter int RADIUS = 6
) (
  input  logic signed [10:0] shell_x,
  input  logic signed [10:0] shell_y,
  input  logic        [9:0]  target_x,
  input  logic        [9:0]  target_y,
  output logic               in_box
);

  localparam logic signed [11:0] Rad = 12'(RADIUS);

  logic signed [11:0] dx, dy, adx, ady;

  // Absolute differences in 12 bits so an off-screen shell cannot wrap into the box.
  always_comb begin
    dx     = $signed({shell_x[10], shell_x}) - $signed({2'b00, target_x});
    dy     = $signed({shell_y[10], shell_y}) - $signed({2'b00, target_y});
    adx    = dx[11] ? -dx : dx;
    ady    = dy[11] ? -dy : dy;
    in_box = (adx <= Rad) && (ady <= Rad);
  end

endmodule

// File: rtl/shell_ctrl.sv
// Ballistic shell controller: launches on shoot, flies one step per frame, pulses hit on impact.
module shell_ctrl
  import tank_pkg::*;
#(
  parameter int X_SPEED    = 4,
  parameter int GRAVITY    = 1,
  parameter int HIT_RADIUS = 6,
  parameter int GROUND_Y   = 470,
  parameter int MAX_FLIGHT = 255
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       shoot,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [1:0] Direction,
  input  logic [9:0] y_component,
  input  logic [9:0] TargetX,
  input  logic [9:0] TargetY,
  output logic [9:0] ShellX,
  output logic [9:0] ShellY,
  output logic       active,
  output logic       hit
);

  localparam int CntW = (MAX_FLIGHT < 2) ? 1 : $clog2(MAX_FLIGHT + 1);

  localparam logic signed [10:0] GroundY = 11'(GROUND_Y);
  localparam logic signed [10:0] XMax    = 11'(SCREEN_X_MAX);
  localparam logic signed [11:0] Grav    = 12'(GRAVITY);
  localparam logic signed [11:0] VyMax   = 12'sd31;
  localparam logic [CntW-1:0]    CntMax  = CntW'(MAX_FLIGHT);

  shell_state_t state;

  logic signed [10:0] pos_x, pos_y, vel_x, vel_y;
  logic [CntW-1:0]    count;

  logic               in_box;
  logic               out_of_play;
  logic signed [10:0] nxt_x, nxt_y, nxt_vy;
  logic signed [11:0] vy_sum;

  box_collide #(
    .RADIUS(HIT_RADIUS)
  ) u_box_collide (
    .shell_x (pos_x),
    .shell_y (pos_y),
    .target_x(TargetX),
    .target_y(TargetY),
    .in_box  (in_box)
  );

  // Next flight step and termination test, both from the current registered position.
  always_comb begin
    nxt_x       = pos_x + vel_x;
    nxt_y       = pos_y + vel_y;
    vy_sum      = $signed({vel_y[10], vel_y}) + Grav;
    nxt_vy      = (vy_sum > VyMax) ? VyMax[10:0] : vy_sum[10:0];
    // Y above the screen (negative) is allowed; the shell just arcs back down.
    out_of_play = (pos_y >= GroundY) || pos_x[10] || (pos_x > XMax) || (count == CntMax);
  end

  // Shell FSM with all outputs registered alongside the state.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      pos_x  <= '0;
      pos_y  <= '0;
      vel_x  <= '0;
      vel_y  <= '0;
      count  <= '0;
      ShellX <= '0;
      ShellY <= '0;
      active <= 1'b0;
      hit    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          hit <= 1'b0;
          if (shoot) begin
            pos_x  <= $signed({1'b0, TankX});
            pos_y  <= $signed({1'b0, TankY});
            vel_y  <= $signed({y_component[9], y_component});
            unique case (Direction)
              2'd0:    vel_x <= -11'(X_SPEED);
              2'd1:    vel_x <= 11'(X_SPEED);
              default: vel_x <= '0;
            endcase
            count  <= '0;
            ShellX <= TankX;
            ShellY <= TankY;
            active <= 1'b1;
            state  <= FLIGHT;
          end
        end
        FLIGHT: begin
          // Hit is checked first so it wins over ground, edge and timeout.
          if (in_box) begin
            hit    <= 1'b1;
            active <= 1'b0;
            state  <= IMPACT;
          end else if (out_of_play) begin
            active <= 1'b0;
            state  <= IDLE;
          end else begin
            pos_x  <= nxt_x;
            pos_y  <= nxt_y;
            vel_y  <= nxt_vy;
            count  <= count + 1'b1;
            ShellX <= nxt_x[9:0];
            ShellY <= screen_y(nxt_y);
          end
        end
        IMPACT: begin
          hit   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          hit    <= 1'b0;
          active <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shell_ctrl.sv
// Self-checking bench for shell_ctrl: directed scenarios plus randomized flights vs a reference model.
module tb_shell_ctrl;

  localparam int XS = 4;
  localparam int G  = 1;
  localparam int R  = 6;
  localparam int GY = 470;
  localparam int MF = 255;

  logic       frame_clk;
  logic       Reset;
  logic       shoot;
  logic [9:0] TankX, TankY, TargetX, TargetY, y_component;
  logic [1:0] Direction;
  logic [9:0] ShellX, ShellY;
  logic       active, hit;

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = waiting, 1 = in flight, 2 = impact frame.
  int m_phase, mx, my, mvx, mvy, mcnt;
  bit m_active, m_hit;

  shell_ctrl #(
    .X_SPEED   (XS),
    .GRAVITY   (G),
    .HIT_RADIUS(R),
    .GROUND_Y  (GY),
    .MAX_FLIGHT(MF)
  ) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .shoot      (shoot),
    .TankX      (TankX),
    .TankY      (TankY),
    .Direction  (Direction),
    .y_component(y_component),
    .TargetX    (TargetX),
    .TargetY    (TargetY),
    .ShellX     (ShellX),
    .ShellY     (ShellY),
    .active     (active),
    .hit        (hit)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    mx       = 0;
    my       = 0;
    mvx      = 0;
    mvy      = 0;
    mcnt     = 0;
    m_active = 1'b0;
    m_hit    = 1'b0;
  endtask

  task automatic model_step();
    if (m_phase == 0) begin
      m_hit = 1'b0;
      if (shoot) begin
        mx       = int'(TankX);
        my       = int'(TankY);
        mvy      = int'($signed(y_component));
        mvx      = (Direction == 2'd0) ? -XS : (Direction == 2'd1) ? XS : 0;
        mcnt     = 0;
        m_phase  = 1;
        m_active = 1'b1;
      end
    end else if (m_phase == 1) begin
      if (iabs(mx - int'(TargetX)) <= R && iabs(my - int'(TargetY)) <= R) begin
        m_phase  = 2;
        m_hit    = 1'b1;
        m_active = 1'b0;
      end else if (my >= GY || mx < 0 || mx > 639 || mcnt == MF) begin
        m_phase  = 0;
        m_active = 1'b0;
      end else begin
        mx   = mx + mvx;
        my   = my + mvy;
        mvy  = (mvy + G > 31) ? 31 : mvy + G;
        mcnt = mcnt + 1;
      end
    end else begin
      m_hit   = 1'b0;
      m_phase = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".ShellX"}, 32'(ShellX), 32'(mx & 1023));
    chk({tag, ".ShellY"}, 32'(ShellY), (my < 0) ? 32'd0 : 32'(my & 1023));
    chk({tag, ".active"}, 32'(active), 32'(m_active));
    chk({tag, ".hit"}, 32'(hit), 32'(m_hit));
  endtask

  task automatic tick(input string tag);
    @(posedge frame_clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  task automatic launch(input string tag, input int tx, input int ty, input int dir,
                        input int yc, input int tgx, input int tgy);
    TankX       = 10'(tx);
    TankY       = 10'(ty);
    Direction   = 2'(dir);
    y_component = 10'(yc);
    TargetX     = 10'(tgx);
    TargetY     = 10'(tgy);
    shoot       = 1'b1;
    tick({tag, ".launch"});
    shoot = 1'b0;
  endtask

  // Run until the model is idle; jitter drives spurious shoot pulses and tank moves in flight.
  task automatic run_to_idle(input string tag, input bit jitter);
    int n = 0;
    while (m_phase != 0 && n < 400) begin
      if (jitter) begin
        shoot = ($urandom_range(0, 2) == 0);
        TankX = 10'($urandom_range(0, 639));
        TankY = 10'($urandom_range(0, 470));
      end
      tick(tag);
      n++;
    end
    shoot = 1'b0;
    chk({tag, ".bound"}, 32'(n < 400), 32'd1);
    chk({tag, ".idle_active"}, 32'(active), 32'd0);
  endtask

  initial begin
    Reset       = 1'b1;
    shoot       = 1'b0;
    TankX       = '0;
    TankY       = '0;
    Direction   = '0;
    y_component = '0;
    TargetX     = '0;
    TargetY     = '0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge frame_clk);
    Reset = 1'b0;
    tick("post_reset");

    // Rightward flat launch, target far away.
    launch("right", 100, 200, 1, 0, 600, 100);
    tick("right");
    chk("right.x1", 32'(ShellX), 32'd104);
    tick("right");
    chk("right.y2", 32'(ShellY), 32'd201);
    tick("right");
    chk("right.x3", 32'(ShellX), 32'd112);
    chk("right.y3", 32'(ShellY), 32'd203);
    run_to_idle("right", 1'b0);

    // Same launch toward a target on the trajectory.
    launch("target", 100, 200, 1, 0, 116, 206);
    run_to_idle("target", 1'b0);

    // Ground termination at Y=470.
    launch("ground", 300, 460, 0, 0, 600, 100);
    for (int i = 0; i < 5; i++) tick("ground");
    chk("ground.y_last", 32'(ShellY), 32'd470);
    run_to_idle("ground", 1'b0);

    // Left edge termination after X goes negative.
    launch("left_edge", 6, 200, 0, 0, 600, 100);
    run_to_idle("left_edge", 1'b0);

    // Shoot reasserted in flight is ignored; a new shot afterwards works.
    launch("reshoot", 200, 300, 1, -10, 600, 30);
    run_to_idle("reshoot", 1'b1);
    launch("reshoot2", 50, 100, 2, -5, 50, 120);
    run_to_idle("reshoot2", 1'b0);

    // Reset mid-flight clears outputs at once with no hit.
    launch("midreset", 100, 200, 1, 0, 600, 100);
    tick("midreset");
    tick("midreset");
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check_outputs("midreset.async");
    @(negedge frame_clk);
    Reset = 1'b0;
    tick("midreset.held");
    launch("after_reset", 100, 200, 1, 0, 116, 206);
    run_to_idle("after_reset", 1'b0);

    // Randomized flights, half with a target near the launch point.
    for (int k = 0; k < 30; k++) begin
      int tx, ty, tgx, tgy;
      tx = int'($urandom_range(0, 639));
      ty = int'($urandom_range(0, 470));
      if ($urandom_range(0, 1) == 1) begin
        tgx = tx + int'($urandom_range(0, 24)) - 12;
        tgy = ty + int'($urandom_range(0, 40)) - 20;
        if (tgx < 0) tgx = 0;
        if (tgy < 0) tgy = 0;
        if (tgx > 639) tgx = 639;
        if (tgy > 479) tgy = 479;
      end else begin
        tgx = int'($urandom_range(0, 639));
        tgy = int'($urandom_range(0, 479));
      end
      launch("rand", tx, ty, int'($urandom_range(0, 3)), int'($urandom_range(0, 30)) - 20,
             tgx, tgy);
      run_to_idle("rand", $urandom_range(0, 1) == 1);
      tick("rand.gap");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shell_ctrl.md
SHELL_CTRL -- requirements
Module: shell_ctrl

Interface
REQ-001 SHALL have parameter X_SPEED, default 4, horizontal shell speed in pixels per frame.
REQ-002 SHALL have parameter GRAVITY, default 1, vertical speed increment per frame.
REQ-003 SHALL have parameter HIT_RADIUS, default 6, half-width of the hit box in pixels.
REQ-004 SHALL have parameter GROUND_Y, default 470; a shell at or below this Y is a miss.
REQ-005 SHALL have parameter MAX_FLIGHT, default 255, frame timeout.
REQ-006 SHALL have port frame_clk, input, 1, clock; one cycle is one video frame.
REQ-007 SHALL have port Reset, input, 1; reset is Reset, asynchronous, active-high, and the clock is frame_clk.
REQ-008 SHALL have port shoot, input, 1, fire pulse from the shooting tank.
REQ-009 SHALL have ports TankX and TankY, input, 10 each, shooter position.
REQ-010 SHALL have port Direction, input, 2; 0 = left, 1 = right, 2/3 = vertical.
REQ-011 SHALL have port y_component, input, 10, signed launch vertical speed; negative means upward.
REQ-012 SHALL have ports TargetX and TargetY, input, 10 each, opposing tank position.
REQ-013 SHALL have ports ShellX and ShellY, output, 10 each, shell position for the renderer.
REQ-014 SHALL have port active, output, 1, high while a shell is in flight.
REQ-015 SHALL have port hit, output, 1, one-frame pulse that drives the target tank's hit input.

Function
REQ-016 SHALL implement an FSM with states IDLE, FLIGHT and IMPACT; all outputs SHALL be registered.
REQ-017 In IDLE with shoot=1:
- latch X=TankX, Y=TankY, vy=y_component
- set vx = -X_SPEED (Direction 0), +X_SPEED (Direction 1), or 0 (Direction 2/3)
- clear the flight counter
- enter FLIGHT; active rises on the same edge.
REQ-018 In FLIGHT, on each edge, the block SHALL evaluate the current registered position in priority order:
- if |X-TargetX| <= HIT_RADIUS and |Y-TargetY| <= HIT_RADIUS, enter IMPACT
- else if Y >= GROUND_Y (signed), X < 0, X > 639, or counter == MAX_FLIGHT, enter IDLE with no hit
- else update X += vx, Y += vy, vy = min(vy+GRAVITY, +31) using old values, and increment the counter.
REQ-019 A hit SHALL take priority over a ground, edge or timeout termination in the same frame.
REQ-020 On entry to IMPACT, hit SHALL be 1 for exactly one cycle and active SHALL be 0; IMPACT SHALL then go to IDLE unconditionally.
REQ-021 shoot SHALL be ignored in FLIGHT and IMPACT; there is no queueing.
REQ-022 Internal X, Y and vy SHALL be 11-bit signed; the 10-bit y_component SHALL be sign-extended.
REQ-023 ShellY SHALL output 0 while Y < 0; ShellX SHALL output X[9:0].
REQ-024 Y < 0 SHALL NOT terminate flight; the shell can arc above the screen.

Reset
REQ-025 Reset SHALL asynchronously force state=IDLE, X=Y=vx=vy=0, counter=0, ShellX=ShellY=0, active=0 and hit=0.
REQ-026 Reset asserted mid-flight SHALL abort the shell with no hit pulse.

Structure
REQ-027 Package tank_pkg SHALL hold the shell_state_t enum, SCREEN_X_MAX=639 and SCREEN_Y_MAX=479.
REQ-028 The hit-box test SHALL be the sub-module box_collide, a combinational absolute-difference compare.

Verification
REQ-029 TankX=100, TankY=200, Direction=1, y_component=0, shoot pulse -> Shell (X,Y) = (100,200), (104,200), (108,201), (112,203) on successive frames; active=1.
REQ-030 Same launch with Target=(116,206) -> at position (116,206), hit=1 for exactly one cycle, then active=0 and state IDLE.
REQ-031 TankX=300, TankY=460, Direction=0, Target=(600,100) -> Y sequence 460, 460, 461, 463, 466, 470, then IDLE; hit never asserted.
REQ-032 TankX=6, Direction=0 -> X sequence 6, 2, -2, then IDLE with no hit; ShellX output is never used after termination.
REQ-033 shoot reasserted during flight -> trajectory unchanged; after landing, a new shoot launches normally.
REQ-034 Reset asserted at frame 3 of a flight -> outputs are 0 immediately with no hit; shoot after release launches normally.
